apu_pwm_sampler: RTL and testbench

- Receiver for the APU mixer's 1-bit PWM audio stream. The mixer produces one PWM period every 256 clocks, high for `sample` cycles.
- This block recovers the mixed 8-bit sample by counting high cycles over each fixed window. Recovered samples are buffered in a small FIFO.
- Samples are delivered over a valid/ready handshake to a downstream PCM consumer (I2S/HDMI audio packetiser).
- Sits in the audio output path, on the same clock as the APU mixer.

---
 rtl/apu_pwm_sampler.sv | 121 ++++++++++++
 tb/tb_apu_pwm_sampler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apu_pwm_sampler.sv
// Recovers 8-bit samples from the APU mixer's PWM stream by counting high
// cycles over fixed 2^WINDOW_BITS windows, buffering results in a small FIFO.
module apu_pwm_sampler #(
  parameter int WINDOW_BITS = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int IN_STAGES   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          pwm_in,
  output logic [WINDOW_BITS-1:0]        sample_out,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int HC_W  = WINDOW_BITS + 1;
  localparam logic [WINDOW_BITS-1:0] WIN_LAST = '1;
  localparam logic [LVL_W-1:0]       LVL_FULL = LVL_W'(FIFO_DEPTH);

  // An all-high window counts to exactly 2^W, one past the sample range.
  function automatic logic [WINDOW_BITS-1:0] sat_count(input logic [HC_W-1:0] cnt);
    if (cnt[WINDOW_BITS])
      return '1;
    else
      return cnt[WINDOW_BITS-1:0];
  endfunction

  // Stage p0: input register chain
  logic [IN_STAGES-1:0] pwm_p0;
  logic                 bit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p0 <= '0;
    end else begin
      pwm_p0[0] <= pwm_in;
      for (int i = 1; i < IN_STAGES; i++)
        pwm_p0[i] <= pwm_p0[i-1];
    end
  end

  assign bit_d = pwm_p0[IN_STAGES-1];

  // Stage p1: window position and high-cycle count
  logic [WINDOW_BITS-1:0] win_p1;
  logic [HC_W-1:0]        hc_p1;
  logic                   win_end_p1;
  logic [WINDOW_BITS-1:0] result_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1 <= '0;
      hc_p1  <= '0;
    end else if (!enable) begin
      win_p1 <= '0;
      hc_p1  <= '0;
    end else begin
      win_p1 <= win_p1 + WINDOW_BITS'(1);
      if (win_p1 == '0)
        hc_p1 <= HC_W'(bit_d);
      else
        hc_p1 <= hc_p1 + HC_W'(bit_d);
    end
  end

  assign win_end_p1 = enable && (win_p1 == WIN_LAST);
  assign result_p1  = sat_count(hc_p1 + HC_W'(bit_d));

  // Stage p2: sample FIFO and overflow flag
  logic [WINDOW_BITS-1:0] mem_p2 [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       level;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  assign full = (level == LVL_FULL);
  assign pop  = sample_valid && sample_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = win_end_p1 && (!full || pop);
  assign drop = win_end_p1 && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_p2[i] <= '0;
    end else begin
      if (push) begin
        mem_p2[wr_ptr] <= result_p1;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        level <= level + LVL_W'(1);
      else if (pop && !push)
        level <= level - LVL_W'(1);
      if (drop)
        overflow <= 1'b1;
      else if (clear_overflow)
        overflow <= 1'b0;
    end
  end

  assign sample_out   = mem_p2[rd_ptr];
  assign sample_valid = (level != '0);
  assign fifo_level   = level;

endmodule

// File: tb/tb_apu_pwm_sampler.sv
// Directed bench for apu_pwm_sampler: PWM patterns with hand-computed sample
// values, FIFO fill/overflow, coincident push/pop, reset and enable aborts.
module tb_apu_pwm_sampler;

  localparam int W         = 8;
  localparam int D         = 4;
  localparam int IN_STAGES = 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] sample_out;
  logic         sample_valid;
  logic         sample_ready = 1'b0;
  logic [2:0]   fifo_level;
  logic         overflow;
  logic         clear_overflow = 1'b0;

  int checks = 0;
  int errors = 0;
  int ec     = 0;
  int mode   = 0;
  int cval   = 0;
  int phase  = 0;
  int s_mix  = 0;
  int sched [16];
  int got_q [$];

  apu_pwm_sampler #(
    .WINDOW_BITS(W),
    .FIFO_DEPTH (D),
    .IN_STAGES  (IN_STAGES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .pwm_in        (pwm_in),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .fifo_level    (fifo_level),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // PWM value driven ahead of edge j.
  // mode 0: constant, mode 1: free-running mixer, mode 2: window-aligned schedule
  function automatic logic gen(input int j);
    int p;
    case (mode)
      0: return cval[0];
      1: return ((j + phase) % 256) < s_mix;
      2: begin
        p = j + IN_STAGES;
        return (p % 256) >= (256 - sched[(p / 256) % 16]);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    if (sample_valid && sample_ready)
      got_q.push_back(int'(sample_out));
    @(posedge clk);
    #1;
    ec++;
    pwm_in = gen(ec);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic run_to(input int target);
    while (ec < target) tick();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_rst_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_rst_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_rst_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_rst_out"}, 32'(sample_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ec = 0;
    pwm_in = gen(0);
    got_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sched[i] = 0;
    #2;

    // Free-running mixer at s=0x40, arbitrary phase
    mode = 1; phase = 37; s_mix = 'h40; enable = 1'b1; sample_ready = 1'b1;
    do_reset("init");
    run(4 * 256 + 20);
    chk("mix_count", 32'(got_q.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("mix_val", 32'(got_q[i]), 32'h40);

    // All-high saturates, all-low gives zero
    mode = 0; cval = 1;
    run(276);
    got_q.delete();
    run(768);
    chk("high_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("high_val", 32'(got_q[i]), 32'hFF);
    chk("high_ovf", 32'(overflow), 32'd0);

    cval = 0;
    run(276);
    got_q.delete();
    run(768);
    chk("low_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("low_val", 32'(got_q[i]), 32'h00);
    chk("low_ovf", 32'(overflow), 32'd0);

    // Six windows with no consumer: fill, drop, clear, drop-beats-clear
    mode = 2;
    for (int i = 0; i < 16; i++) sched[i] = i + 1;
    sample_ready = 1'b0;
    do_reset("ovf");
    run_to(255);
    chk("ovf_lvl0", 32'(fifo_level), 32'd0);
    run_to(256);
    chk("ovf_lvl1", 32'(fifo_level), 32'd1);
    chk("ovf_head1", 32'(sample_out), 32'd1);
    run_to(1023);
    chk("ovf_lvl3", 32'(fifo_level), 32'd3);
    run_to(1024);
    chk("ovf_lvl4", 32'(fifo_level), 32'd4);
    chk("ovf_pre", 32'(overflow), 32'd0);
    run_to(1279);
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    run_to(1280);
    chk("ovf_after_drop", 32'(overflow), 32'd1);
    chk("ovf_lvl_full", 32'(fifo_level), 32'd4);
    chk("ovf_head_stable", 32'(sample_out), 32'd1);
    run_to(1400);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    run_to(1535);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_drop_wins", 32'(overflow), 32'd1);
    sample_ready = 1'b1;
    run(8);
    chk("ovf_drain_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("ovf_drain_val", 32'(got_q[i]), 32'(i + 1));
    chk("ovf_drain_lvl", 32'(fifo_level), 32'd0);

    // Full FIFO with a pop exactly on the window-end push
    for (int i = 0; i < 16; i++) sched[i] = 10 + i;
    sample_ready = 1'b0;
    do_reset("full");
    run_to(1024);
    chk("full_lvl4", 32'(fifo_level), 32'd4);
    run_to(1279);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    chk("full_lvl_same", 32'(fifo_level), 32'd4);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    chk("full_head", 32'(sample_out), 32'd11);
    sample_ready = 1'b1;
    run(6);
    chk("full_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("full_order", 32'(got_q[i]), 32'(10 + i));

    // Reset mid-window while two samples are buffered
    sample_ready = 1'b0;
    run(600);
    chk("mid_lvl2", 32'(fifo_level), 32'd2);
    sched[0] = 'h37;
    do_reset("mid");
    sample_ready = 1'b1;
    run_to(255);
    chk("mid_not_yet", 32'(sample_valid), 32'd0);
    run_to(256);
    chk("mid_valid", 32'(sample_valid), 32'd1);
    chk("mid_val", 32'(sample_out), 32'h37);

    // Enable dropped for 100 cycles mid-window, constant s=0x80
    mode = 1; phase = 100; s_mix = 'h80;
    do_reset("en");
    run_to(300);
    got_q.delete();
    enable = 1'b0;
    run_to(400);
    chk("en_idle_lvl", 32'(fifo_level), 32'd0);
    enable = 1'b1;
    run_to(655);
    chk("en_no_sample", 32'(got_q.size()), 32'd0);
    chk("en_not_yet", 32'(sample_valid), 32'd0);
    run_to(656);
    chk("en_valid", 32'(sample_valid), 32'd1);
    chk("en_val", 32'(sample_out), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
